uart_tx_parity: RTL
===================

Name: uart_tx_parity

Overview:
- Transmit half of the UART: serialises one INPUT_DATA_WIDTH-bit word per frame.
- Frame order: start bit (0), data LSB-first, even parity bit, one stop bit (1).
- Parity bit equals the XOR of the data bits, so the count of ones across data plus parity is even. This matches the convention of the Rx parity checker.
- Sits between the host-side byte source and the serial line pin. It has its own bit-period counter.

Parameters:
- INPUT_DATA_WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  INPUT_DATA_WIDTH  word to send; sampled only on an accept.
- tx_start  in  1  request to send tx_data.
- tx_ready  out  1  high when idle and able to accept.
- serial_out  out  1  serial line; idles high.
- is_parity_stage  out  1  high during every cycle the parity bit is driven.

Behaviour:
- Reset (synchronous, takes effect the cycle after reset is sampled high):
  - serial_out=1, tx_ready=1, is_parity_stage=0.
  - State IDLE; bit counter, clock counter and shift register cleared.
- Accept: tx_start && tx_ready sampled high in cycle N.
  - Capture tx_data into the shift register.
  - Compute parity_value = ^tx_data at capture.
  - State moves to START.
- tx_start while tx_ready=0 is ignored, with no queuing. Changes on tx_data after accept have no effect.
- States and durations (C = CLKS_PER_BIT, W = INPUT_DATA_WIDTH); every bit lasts exactly C cycles:
  - IDLE: serial_out=1, tx_ready=1.
  - START: serial_out=0 for cycles N+1..N+C.
  - DATA: W bits, LSB first. Bit k is driven on cycles N+1+(k+1)C .. N+(k+2)C.
  - PARITY: serial_out=parity_value and is_parity_stage=1 for C cycles.
  - STOP: serial_out=1 for C cycles, then back to IDLE.
- tx_ready timing: falls at N+1. It rises again at N+1+F, where F=(W+3)*C. All outputs are registered.
- Back-to-back frames: an accept at N+1+F starts the next start bit at N+2+F. There is a guaranteed minimum of one idle-high cycle between frames.
- Bit timing: clock counter width is $clog2(C) (minimum 1). It counts 0..C-1 and wraps, and each wrap advances the state/bit.
- Bit counter width is $clog2(W) (minimum 1). It wraps to 0 on DATA exit.
- C=1: each bit lasts one cycle; no special case allowed.
- Reset mid-frame: the frame is abandoned. serial_out=1 and tx_ready=1 on the next cycle, with no partial stop bit. tx_start in the same cycle as reset is ignored.
- serial_out must never glitch. It is driven from a flop, with no combinational path from tx_start or tx_data.

Decomposition:
- Shared uart package holds:
  - State encoding localparams IDLE/START/DATA/PARITY/STOP (3-bit).
  - Frame constants START_BIT=0, STOP_BIT=1.
  - INPUT_DATA_WIDTH default.
  - A function even_parity(data) = ^data, for reuse by the Rx path.
- One sub-module is natural: baud_counter (CLKS_PER_BIT parameter; inputs clk, reset, clear; output bit_done pulsed on wrap). The FSM and shift register stay in uart_tx_parity.

Test Plan:
- C=4, idle, no start, 20 cycles -> serial_out=1 and tx_ready=1 throughout.
- C=4, send 0xA5 -> line shows 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1. Each bit lasts 4 cycles. is_parity_stage high for exactly 4 cycles. tx_ready low for 44 cycles.
- C=4, send 0x01 then 0x07 back-to-back on the first tx_ready cycle -> parity 1 for both. Exactly 1 idle-high cycle between stop and the next start.
- C=4, tx_start pulsed with tx_data=0xFF during the data phase of a 0x3C frame -> 0x3C frame unaffected (parity 0), no second frame sent.
- C=4, reset asserted one cycle during DATA bit 3 -> serial_out=1 and tx_ready=1 the next cycle. A following 0x80 frame is correct (parity 1).
- C=1, send 0x00 -> 11-cycle frame 0,00000000,0,1. tx_ready rises at N+12.

Source files
------------

// File: rtl/uart_tx_parity_pkg.sv
// Shared UART definitions: state encoding, frame bit levels and parity helper.
// Used by the Tx path here and by the Rx parity checker.
package uart_tx_parity_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Wide input so any word width up to 64 can be zero-extended in; padding zeros keep parity.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_parity_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_done on the last count.
// One-cycle-registered count, bit_done is decoded from it; clear holds the count at zero.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_done = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, LSB-first data, even parity, one stop bit; first bit one cycle after accept.
// Accepts only when tx_ready is high; tx_start while busy is dropped, nothing is queued.
module uart_tx_parity
    import uart_tx_parity_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
    input  logic                        tx_start,
    output logic                        tx_ready,
    output logic                        serial_out,
    output logic                        is_parity_stage
);

    localparam int W   = INPUT_DATA_WIDTH;
    localparam int BCW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

    tx_state_t      state;
    logic [W-1:0]   shift_reg;
    logic [BCW-1:0] bit_cnt;
    logic           parity_value;
    logic           bit_done;
    logic           baud_clear;

    // Timer is held at zero while idle so the start bit gets a full period from the accept.
    assign baud_clear = (state == ST_IDLE);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            parity_value    <= 1'b0;
            serial_out      <= STOP_BIT;
            tx_ready        <= 1'b1;
            is_parity_stage <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        shift_reg    <= tx_data;
                        parity_value <= even_parity(64'(tx_data));
                        serial_out   <= START_BIT;
                        tx_ready     <= 1'b0;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        serial_out <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                        bit_cnt    <= '0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt         <= '0;
                            serial_out      <= parity_value;
                            is_parity_stage <= 1'b1;
                            state           <= ST_PARITY;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            serial_out <= shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        serial_out      <= STOP_BIT;
                        is_parity_stage <= 1'b0;
                        state           <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        tx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    serial_out      <= STOP_BIT;
                    tx_ready        <= 1'b1;
                    is_parity_stage <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
